// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: owns the PC, issues credit-limited imem requests, buffers {pc,instr} for decode.
// Optional FETCH_PERF_CNT_EN adds the perf_fetched delivered-instruction counter port.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_pc,
   output logic [31:0] dec_instr
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched
`endif
);

   localparam int          c_CW    = $clog2(FIFO_DEPTH + 1);
   localparam int          c_PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [c_CW:0] c_DEPTH = (c_CW + 1)'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      S_RUN   = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [c_CW-1:0]   r_drop;
   logic [c_CW-1:0]   w_drop_nxt;

   logic [31:0]       r_pc;
   logic [c_CW-1:0]   r_out;
   logic [c_CW-1:0]   r_fcnt;
   logic [c_PW-1:0]   r_frd;
   logic [c_PW-1:0]   r_fwr;
   logic [31:0]       r_fpc  [FIFO_DEPTH];
   logic [31:0]       r_fins [FIFO_DEPTH];
   logic [31:0]       r_tpc  [FIFO_DEPTH];
   logic [c_PW-1:0]   r_trd;
   logic [c_PW-1:0]   r_twr;

   logic              w_credit;
   logic              w_req_fire;
   logic              w_push;
   logic              w_pop;

   function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
      ptr_inc = (p == c_PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Buffered entries count against credits so a response always has a slot.
   assign w_credit       = ({1'b0, r_out} + {1'b0, r_fcnt}) < c_DEPTH;
   assign imem_req_valid = rst_n && !redirect_valid && w_credit;
   assign imem_req_addr  = r_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   assign dec_valid = rst_n && !redirect_valid && (r_fcnt != '0);
   assign dec_pc    = r_fpc[r_frd];
   assign dec_instr = r_fins[r_frd];
   assign w_pop     = dec_valid && dec_ready;
   assign w_push    = imem_rsp_valid && (r_state == S_RUN) && !redirect_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_RUN;
         r_drop  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_drop  <= w_drop_nxt;
      end
   end

   // A response arriving in the redirect cycle is itself discarded, hence the subtraction.
   always_comb begin
      w_drop_nxt  = r_drop;
      w_state_nxt = r_state;
      if (redirect_valid) begin
         w_drop_nxt = r_out - c_CW'(imem_rsp_valid);
      end else if (imem_rsp_valid && (r_state == S_DRAIN)) begin
         w_drop_nxt = r_drop - 1'b1;
      end
      w_state_nxt = (w_drop_nxt != '0) ? S_DRAIN : S_RUN;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc   <= RESET_PC;
         r_out  <= '0;
         r_fcnt <= '0;
         r_frd  <= '0;
         r_fwr  <= '0;
         r_trd  <= '0;
         r_twr  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fpc[i]  <= '0;
            r_fins[i] <= '0;
            r_tpc[i]  <= '0;
         end
      end else begin
         r_out <= r_out + c_CW'(w_req_fire) - c_CW'(imem_rsp_valid);
         if (w_req_fire) begin
            r_pc         <= r_pc + 32'd4;
            r_tpc[r_twr] <= r_pc;
            r_twr        <= ptr_inc(r_twr);
         end
         // Tag queue tracks every outstanding request, dropped ones included.
         if (imem_rsp_valid) begin
            r_trd <= ptr_inc(r_trd);
         end
         if (redirect_valid) begin
            r_pc   <= {redirect_pc[31:2], 2'b00};
            r_fcnt <= '0;
            r_frd  <= '0;
            r_fwr  <= '0;
         end else begin
            if (w_push) begin
               r_fpc[r_fwr]  <= r_tpc[r_trd];
               r_fins[r_fwr] <= imem_rsp_data;
               r_fwr         <= ptr_inc(r_fwr);
            end
            if (w_pop) begin
               r_frd <= ptr_inc(r_frd);
            end
            r_fcnt <= r_fcnt + c_CW'(w_push) - c_CW'(w_pop);
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_perf <= '0;
      end else if (w_pop) begin
         r_perf <= r_perf + 32'd1;
      end
   end

   assign perf_fetched = r_perf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: directed checks of fetch_unit against a behavioural in-order imem.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [31:0] dec_pc;
   logic [31:0] dec_instr;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched;
`endif

   fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_pc         (dec_pc),
      .dec_instr      (dec_instr)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched   (perf_fetched)
`endif
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_bad = 0;
   int          lat = 1;
   int          cyc = 0;
   logic [31:0] q_a [$];
   int          q_c [$];
   logic [31:0] req_log [$];
   logic [31:0] got_pc [$];
   logic [31:0] got_ins [$];

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      instr_of = (a * 32'd3) ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // In-order imem with programmable latency, plus handshake logging on both sides.
   always begin
      @(posedge clk);
      if (!rst_n) begin
         q_a.delete();
         q_c.delete();
      end else begin
         if (imem_req_valid && imem_req_ready) begin
            q_a.push_back(imem_req_addr);
            q_c.push_back(cyc);
            req_log.push_back(imem_req_addr);
         end
         if (dec_valid && dec_ready) begin
            got_pc.push_back(dec_pc);
            got_ins.push_back(dec_instr);
         end
      end
      cyc++;
      @(negedge clk);
      if (rst_n && (q_a.size() > 0) && ((cyc - q_c[0]) >= lat)) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = instr_of(q_a.pop_front());
         void'(q_c.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
   end

   task automatic quiesce();
      imem_req_ready = 1'b0;
      dec_ready      = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic check_stream(input int rb, input int gb, input logic [31:0] first);
      int nr;
      int ng;
      nr = req_log.size() - rb;
      ng = got_pc.size() - gb;
      chk("stream_count", 32'(ng), 32'(nr));
      for (int i = 0; i < nr && i < ng; i++) begin
         chk("stream_req", req_log[rb+i], first + 32'(4 * i));
         chk("stream_pc", got_pc[gb+i], first + 32'(4 * i));
         chk("stream_ins", got_ins[gb+i], instr_of(first + 32'(4 * i)));
      end
   endtask

   task automatic wait_reqs(input int rb, input int n);
      for (int k = 0; k < 50 && (req_log.size() - rb) < n; k++) @(negedge clk);
      if ((req_log.size() - rb) < n) chk("wait_reqs_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_got(input int gb, input int n);
      for (int k = 0; k < 100 && (got_pc.size() - gb) < n; k++) @(negedge clk);
      if ((got_pc.size() - gb) < n) chk("wait_got_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int rb;
      int gb;
      int mx;
      int infl;
      bit found;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      chk("rst_dec_pc", dec_pc, 32'h0);
      chk("rst_dec_instr", dec_instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_perf", perf_fetched, 32'h0);
`endif

      // Streaming with 1-cycle imem and first-instruction latency
      @(negedge clk);
      rst_n = 1'b1; imem_req_ready = 1'b1; dec_ready = 1'b1;
      #1;
      chk("s1_req_valid", 32'(imem_req_valid), 32'd1);
      chk("s1_req_addr0", imem_req_addr, 32'h0);
      chk("s1_dec_valid_c0", 32'(dec_valid), 32'd0);
      @(negedge clk); #1;
      chk("s1_dec_valid_c1", 32'(dec_valid), 32'd0);
      chk("s1_req_addr1", imem_req_addr, 32'h4);
      @(negedge clk); #1;
      chk("s1_dec_valid_c2", 32'(dec_valid), 32'd1);
      chk("s1_dec_pc_c2", dec_pc, 32'h0);
      chk("s1_dec_ins_c2", dec_instr, instr_of(32'h0));
      repeat (10) @(negedge clk);
      quiesce();
      check_stream(0, 0, 32'h0);

      // Decode backpressure: credits bound in-flight + buffered to 2
      rb = req_log.size(); gb = got_pc.size(); mx = 0;
      @(negedge clk);
      dec_ready = 1'b0; imem_req_ready = 1'b1;
      repeat (10) begin
         @(negedge clk); #1;
         infl = (req_log.size() - rb) - (got_pc.size() - gb);
         if (infl > mx) mx = infl;
      end
      chk("bp_max_inflight", 32'(mx), 32'd2);
      chk("bp_req_held", 32'(imem_req_valid), 32'd0);
      chk("bp_head_pc", dec_pc, 32'(4 * rb));
      dec_ready = 1'b1;
      repeat (10) @(negedge clk);
      quiesce();
      check_stream(rb, gb, 32'(4 * rb));

      // Redirect with two responses in flight
      rb = req_log.size();
      lat = 4; imem_req_ready = 1'b1; dec_ready = 1'b1;
      wait_reqs(rb, 2);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
      #1;
      chk("r3_req_valid", 32'(imem_req_valid), 32'd0);
      chk("r3_dec_valid", 32'(dec_valid), 32'd0);
      gb = got_pc.size();
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      chk("r3_next_addr", imem_req_addr, 32'h100);
      repeat (25) @(negedge clk);
      quiesce();
      lat = 1;
      chk("r3_first_pc", got_pc[gb], 32'h100);
      check_stream(rb + 2, gb, 32'h100);

      // Redirect colliding with a response and a pending decode pop
      imem_req_ready = 1'b1; dec_ready = 1'b1; found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         @(negedge clk); #1;
         if (dec_valid && imem_rsp_valid) begin
            found = 1'b1;
            redirect_valid = 1'b1; redirect_pc = 32'h0000_0202;
            #1;
            chk("r4_dec_valid", 32'(dec_valid), 32'd0);
            chk("r4_req_valid", 32'(imem_req_valid), 32'd0);
            rb = req_log.size(); gb = got_pc.size();
            @(negedge clk);
            redirect_valid = 1'b0;
            #1;
            chk("r4_fifo_empty", 32'(dec_valid), 32'd0);
            chk("r4_next_addr", imem_req_addr, 32'h200);
         end
      end
      if (!found) chk("r4_setup_timeout", 32'd0, 32'd1);
      repeat (10) @(negedge clk);
      quiesce();
      check_stream(rb, gb, 32'h200);

      // Reset while draining stale responses
      rb = req_log.size();
      lat = 4; imem_req_ready = 1'b1; dec_ready = 1'b1;
      wait_reqs(rb, 2);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
      @(negedge clk);
      redirect_valid = 1'b0; rst_n = 1'b0;
      #1;
      chk("r5_rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("r5_rst_dec_valid", 32'(dec_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; lat = 1;
      #1;
      chk("r5_addr", imem_req_addr, 32'h0);
      chk("r5_req_resume", 32'(imem_req_valid), 32'd1);
      chk("r5_dec_valid", 32'(dec_valid), 32'd0);
      rb = req_log.size(); gb = got_pc.size();
      repeat (10) @(negedge clk);
      quiesce();
      check_stream(rb, gb, 32'h0);

      // Reset with the instruction buffer full
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; dec_ready = 1'b0; imem_req_ready = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      chk("r5b_full_valid", 32'(dec_valid), 32'd1);
      chk("r5b_full_pc", dec_pc, 32'h0);
      chk("r5b_full_req", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("r5b_dec_valid", 32'(dec_valid), 32'd0);
      chk("r5b_addr", imem_req_addr, 32'h0);
      chk("r5b_req_resume", 32'(imem_req_valid), 32'd1);

`ifdef FETCH_PERF_CNT_EN
      // Delivered-instruction counter survives a redirect
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; imem_req_ready = 1'b1; dec_ready = 1'b1;
      gb = got_pc.size();
      wait_got(gb, 5);
      dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
      @(negedge clk);
      redirect_valid = 1'b0; dec_ready = 1'b1;
      wait_got(gb, 8);
      dec_ready = 1'b0;
      #1;
      chk("perf_count", perf_fetched, 32'd8);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
